hs_stage_sequencer: RTL and testbench
=====================================

Name: hs_stage_sequencer

Overview:
- Top-level control FSM for an HLS kernel built from sequential sub-pipelines. Each sub-pipeline is a child block with an ap_ctrl_hs handshake.
- Runs the enabled children strictly in index order, one at a time. Records a per-stage cycle count and enforces a per-stage watchdog.
- Sits between the kernel's ap_start/ap_done interface and the grp_*_fu child instances. The dataflow monitor observes the same handshakes.

Parameters:
- NUM_STAGES, 4, number of child stages sequenced (1..8).
- CNT_W, 32, width of per-stage cycle counters.
- TIMEOUT, 1000000, max cycles a stage may remain running before abort (must be < 2^CNT_W).

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- ap_start  in  1  kernel start request, level.
- stage_en  in  NUM_STAGES  per-stage enable mask, sampled when ap_start is accepted.
- ap_done  out  1  one-cycle pulse, run finished.
- ap_ready  out  1  one-cycle pulse, coincident with ap_done.
- ap_idle  out  1  high in IDLE only.
- stage_start  out  NUM_STAGES  one-hot ap_start to children.
- stage_ready  in  NUM_STAGES  child ap_ready.
- stage_done  in  NUM_STAGES  child ap_done (pulse).
- cur_stage  out  3  index of the running stage (0 when not in RUN).
- err_timeout  out  1  sticky watchdog error.
- cnt_sel  in  3  counter read select.
- cnt_value  out  CNT_W  selected stage cycle count, registered.

Behaviour:
- Reset values:
  - State = IDLE; ap_idle=1.
  - ap_done=ap_ready=0; stage_start=0; cur_stage=0; err_timeout=0.
  - All counters = 0; cnt_value=0.
- States:
  - IDLE: ap_idle=1. If ap_start=1: latch pending_mask=stage_en, clear all counters and err_timeout, go to SELECT.
  - SELECT, 1 cycle: if pending_mask==0, go to FINISH. Otherwise k = lowest set bit of pending_mask; set start_pending=1; go to RUN.
  - RUN:
    - stage_start[k] = start_pending.
    - start_pending clears on the cycle stage_ready[k]=1 is sampled.
    - cnt[k] increments every RUN cycle, including the first, saturating at all-ones.
    - When stage_done[k]=1: clear pending_mask[k], go to SELECT. This holds even if stage_ready[k] arrives in the same cycle, in which case start_pending also clears.
  - FINISH, 1 cycle: ap_done=ap_ready=1; go to IDLE. ap_start is ignored here and is re-sampled in IDLE next cycle.
- Watchdog:
  - In RUN, if cnt[k] reaches TIMEOUT-1 without stage_done, then: set err_timeout=1; deassert stage_start; clear the whole pending_mask; go to SELECT, then FINISH.
  - err_timeout stays high until the next accepted ap_start.
- Ignored inputs:
  - stage_done/stage_ready on any index other than k, or outside RUN, are ignored.
  - stage_en changes after acceptance have no effect.
- Reset mid-run: returns to IDLE within one cycle; stage_start drops the same cycle reset is sampled; counters clear.
- Latency with all children completing on their first RUN cycle:
  - ap_start sampled at cycle 0.
  - Stage i runs at cycle 2+2i.
  - ap_done at cycle 2N+2, i.e. cycle 10 for N=4.
  - Each cnt = 1.
- Empty mask: ap_done at cycle 2.
- cnt_value = cnt[cnt_sel], registered with 1 cycle latency. It is 0 if cnt_sel >= NUM_STAGES. Counters hold their values after FINISH until the next start.
- cur_stage = k during RUN, else 0.

Test Plan:
- Back-to-back run: stage_en=4'b1111, every child asserts ready+done on its first start cycle -> ap_done at cycle 10; stage_start one-hot 0,1,2,3 at cycles 2,4,6,8; cnt_value=1 for all sel 0..3.
- Skipped stages: stage_en=4'b1010, stage 1 done after 5 cycles, stage 3 after 20 -> stage_start[0] and stage_start[2] never asserted; cnt1=5, cnt3=20, cnt0=cnt2=0; ap_done at cycle 2+5+1+20+1=29.
- Held start: stage_ready delayed 3 cycles after stage_start -> stage_start held exactly 3 cycles then drops; done later still advances the sequence; ready and done together in one cycle -> clean advance.
- Watchdog: TIMEOUT=16, stage 2 never done -> stage_start[2] drops after 16 RUN cycles; err_timeout=1; stage 3 not run; ap_done pulses. Next ap_start clears err_timeout.
- Reset mid-run: reset asserted during stage 1 RUN -> next cycle ap_idle=1, stage_start=0, all cnt=0; a new run completes normally.
- Empty mask/spurious inputs: stage_en=0 -> ap_done at cycle 2. stage_done[3] pulsed while stage 0 is running -> ignored, sequence unchanged.

Source files
------------

// File: rtl/hs_stage_sequencer.sv
// hs_stage_sequencer: runs enabled ap_ctrl_hs child stages in index
// order, one at a time, with per-stage cycle counters and a watchdog.
module hs_stage_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ap_start,
  input  logic [NUM_STAGES-1:0] stage_en,
  output logic                  ap_done,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_ready,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [2:0]            cur_stage,
  output logic                  err_timeout,
  input  logic [2:0]            cnt_sel,
  output logic [CNT_W-1:0]      cnt_value
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_RUN,
    S_FINISH
  } state_t;

  localparam logic [CNT_W-1:0] WD_LIMIT =
    CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                  state_q;
  logic [NUM_STAGES-1:0]   mask_q;
  logic [2:0]              k_q;
  logic                    pend_q;
  logic                    err_q;
  logic [CNT_W-1:0]        cnt_q [NUM_STAGES];
  logic [CNT_W-1:0]        cnt_value_q;

  logic [CNT_W-1:0]        cur_cnt;
  logic                    cur_done;
  logic                    cur_ready;
  logic [NUM_STAGES-1:0]   k_oh;
  logic [2:0]              low_idx;
  logic [CNT_W-1:0]        sel_cnt;
  logic                    wd_hit;
  logic                    run;

  // Decode the running stage, the next pending stage and the read mux.
  always_comb begin
    cur_cnt   = '0;
    cur_done  = 1'b0;
    cur_ready = 1'b0;
    k_oh      = '0;
    low_idx   = 3'd0;
    sel_cnt   = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (k_q == 3'(i)) begin
        cur_cnt   = cnt_q[i];
        cur_done  = stage_done[i];
        cur_ready = stage_ready[i];
        k_oh[i]   = 1'b1;
      end
      if (cnt_sel == 3'(i)) begin
        sel_cnt = cnt_q[i];
      end
    end
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        low_idx = 3'(i);
      end
    end
  end

  assign run    = (state_q == S_RUN);
  assign wd_hit = (cur_cnt >= WD_LIMIT);

  // Sequencer FSM: pending mask, running index, counters, watchdog.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      k_q     <= 3'd0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ap_start) begin
            mask_q  <= stage_en;
            err_q   <= 1'b0;
            state_q <= S_SELECT;
            for (int i = 0; i < NUM_STAGES; i++) begin
              cnt_q[i] <= '0;
            end
          end
        end
        S_SELECT: begin
          if (mask_q == '0) begin
            state_q <= S_FINISH;
          end else begin
            k_q     <= low_idx;
            pend_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          for (int i = 0; i < NUM_STAGES; i++) begin
            if (k_q == 3'(i) && cnt_q[i] != CNT_MAX) begin
              cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
          end
          if (cur_ready) begin
            pend_q <= 1'b0;
          end
          if (cur_done) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (k_q == 3'(i)) begin
                mask_q[i] <= 1'b0;
              end
            end
            pend_q  <= 1'b0;
            state_q <= S_SELECT;
          end else if (wd_hit) begin
            err_q   <= 1'b1;
            mask_q  <= '0;
            pend_q  <= 1'b0;
            state_q <= S_SELECT;
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Registered counter readback; unused selects read as zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_value_q <= '0;
    end else begin
      cnt_value_q <= sel_cnt;
    end
  end

  assign ap_idle     = (state_q == S_IDLE);
  assign ap_done     = (state_q == S_FINISH);
  assign ap_ready    = (state_q == S_FINISH);
  assign cur_stage   = run ? k_q : 3'd0;
  assign err_timeout = err_q;
  assign cnt_value   = cnt_value_q;
  // Gate with reset so the child start drops while reset is sampled.
  assign stage_start = (run && pend_q && !reset) ? k_oh : '0;

endmodule

// File: tb/tb_hs_stage_sequencer.sv
// tb_hs_stage_sequencer: scoreboard bench, child models respond to
// stage_start; expected events are queued at launch time.
module tb_hs_stage_sequencer;

  localparam int NS = 4;
  localparam int TMO_A = 1000;
  localparam int TMO_B = 16;

  typedef struct {
    int kind;
    int idx;
    int cyc;
    int hold;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ap_start_a = 1'b0;
  logic ap_start_b = 1'b0;
  logic [NS-1:0] stage_en = '0;
  logic [NS-1:0] stage_ready = '0;
  logic [NS-1:0] stage_done = '0;
  logic [2:0] cnt_sel = 3'd0;

  logic done_a, rdy_a, idle_a, err_a;
  logic done_b, rdy_b, idle_b, err_b;
  logic [NS-1:0] start_a, start_b;
  logic [2:0] cur_a, cur_b;
  logic [31:0] cnt_a, cnt_b;

  logic use_wd = 1'b0;
  logic m_done, m_ready, m_idle, m_err;
  logic [NS-1:0] m_start;
  logic [2:0] m_cur;
  logic [31:0] m_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  ev_t q[$];
  int rdy[NS];
  int dn[NS];
  int exp_cnt[NS];
  int hexp[NS];
  int hcnt[NS];
  logic exp_err;
  logic done_flag = 1'b0;
  logic spur_on = 1'b0;
  logic [NS-1:0] pstart = '0;
  logic [NS-1:0] act = '0;
  logic [NS-1:0] mdone = '0;
  int age[NS];

  hs_stage_sequencer #(
    .NUM_STAGES(NS), .CNT_W(32), .TIMEOUT(TMO_A)
  ) dut (
    .clock(clk), .reset(reset), .ap_start(ap_start_a),
    .stage_en(stage_en), .ap_done(done_a),
    .ap_ready(rdy_a), .ap_idle(idle_a),
    .stage_start(start_a), .stage_ready(stage_ready),
    .stage_done(stage_done), .cur_stage(cur_a),
    .err_timeout(err_a), .cnt_sel(cnt_sel),
    .cnt_value(cnt_a)
  );

  hs_stage_sequencer #(
    .NUM_STAGES(NS), .CNT_W(32), .TIMEOUT(TMO_B)
  ) dut_wd (
    .clock(clk), .reset(reset), .ap_start(ap_start_b),
    .stage_en(stage_en), .ap_done(done_b),
    .ap_ready(rdy_b), .ap_idle(idle_b),
    .stage_start(start_b), .stage_ready(stage_ready),
    .stage_done(stage_done), .cur_stage(cur_b),
    .err_timeout(err_b), .cnt_sel(cnt_sel),
    .cnt_value(cnt_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    m_done  = use_wd ? done_b  : done_a;
    m_ready = use_wd ? rdy_b   : rdy_a;
    m_idle  = use_wd ? idle_b  : idle_a;
    m_err   = use_wd ? err_b   : err_a;
    m_start = use_wd ? start_b : start_a;
    m_cur   = use_wd ? cur_b   : cur_a;
    m_cnt   = use_wd ? cnt_b   : cnt_a;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Child models: ready at age rdy, done on RUN cycle dn (0 = never).
  always @(negedge clk) begin
    logic [NS-1:0] rr, dd, sp;
    rr = '0;
    dd = '0;
    sp = '0;
    if (reset || m_idle) begin
      act = '0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (mdone[i]) act[i] = 1'b0;
        if (!act[i] && m_start[i]) begin
          act[i] = 1'b1;
          age[i] = 0;
        end else if (act[i]) begin
          age[i]++;
        end
        rr[i] = act[i] && age[i] == rdy[i];
        dd[i] = act[i] && dn[i] != 0 && age[i] == dn[i] - 1;
      end
      if (spur_on && act[0] && age[0] == 2) sp[3] = 1'b1;
    end
    mdone = dd;
    stage_ready = rr | sp;
    stage_done = dd | sp;
  end

  // Monitor: pops expected start/done events as the DUT produces them.
  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      chk("onehot", 32'($countones(m_start) <= 1), 1);
      for (int i = 0; i < NS; i++) begin
        if (m_start[i] && !pstart[i]) begin
          hcnt[i] = 1;
          if (q.size() == 0) begin
            chk("extra_start", i, 99);
          end else begin
            e = q.pop_front();
            chk("ev_kind", 0, e.kind);
            chk("start_idx", i, e.idx);
            chk("start_cyc", cyc, e.cyc);
            chk("cur_stage", m_cur, i);
            hexp[i] = e.hold;
          end
        end else if (m_start[i]) begin
          hcnt[i]++;
        end else if (pstart[i] && hexp[i] >= 0) begin
          chk("start_hold", hcnt[i], hexp[i]);
        end
      end
      if (m_done) begin
        chk("ap_ready", m_ready, 1);
        if (q.size() == 0) begin
          chk("extra_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("ev_kind", 1, e.kind);
          chk("done_cyc", cyc, e.cyc);
        end
        done_flag = 1'b1;
      end
    end
    pstart = m_start;
  end

  task automatic launch(input logic [NS-1:0] en,
                        input logic wd);
    int t, l, tmo, h, c0;
    logic to;
    use_wd = wd;
    tmo = wd ? TMO_B : TMO_A;
    stage_en = en;
    done_flag = 1'b0;
    to = 1'b0;
    c0 = cyc;
    t = c0 + 1;
    for (int i = 0; i < NS; i++) exp_cnt[i] = 0;
    for (int i = 0; i < NS; i++) begin
      if (en[i] && !to) begin
        to = (dn[i] == 0 || dn[i] > tmo);
        l = to ? tmo : dn[i];
        h = (rdy[i] + 1 < l) ? rdy[i] + 1 : l;
        q.push_back('{0, i, t + 1, h});
        exp_cnt[i] = l;
        t = t + 1 + l;
      end
    end
    q.push_back('{1, 0, t + 1, 0});
    exp_err = to;
    if (wd) ap_start_b = 1'b1;
    else ap_start_a = 1'b1;
    @(negedge clk);
    ap_start_a = 1'b0;
    ap_start_b = 1'b0;
  endtask

  task automatic check_cnt(input int sel, input int want);
    cnt_sel = 3'(sel);
    @(negedge clk);
    chk($sformatf("cnt%0d", sel), m_cnt, want);
  endtask

  task automatic finish_run();
    int w;
    w = 0;
    while (!done_flag && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("done_seen", done_flag, 1);
    @(negedge clk);
    chk("sb_drain", q.size(), 0);
    chk("idle_after", m_idle, 1);
    chk("err", m_err, exp_err);
    for (int i = 0; i < NS; i++) check_cnt(i, exp_cnt[i]);
    check_cnt(NS, 0);
  endtask

  initial begin
    int w;
    for (int i = 0; i < NS; i++) begin
      rdy[i] = 0; dn[i] = 1; hexp[i] = -1;
      hcnt[i] = 0; age[i] = 0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_idle", m_idle, 1);
    chk("rst_done", m_done, 0);
    chk("rst_ready", m_ready, 0);
    chk("rst_start", m_start, 0);
    chk("rst_cur", m_cur, 0);
    chk("rst_err", m_err, 0);
    chk("rst_cnt", m_cnt, 0);
    chk("rst_wd_idle", idle_b, 1);

    // back-to-back, every child done on first cycle
    launch(4'b1111, 1'b0);
    finish_run();

    // skipped stages
    dn = '{1, 5, 1, 20};
    launch(4'b1010, 1'b0);
    finish_run();

    // held start, ready/done together, done before ready
    rdy = '{2, 2, 0, 5};
    dn  = '{8, 3, 1, 2};
    launch(4'b1111, 1'b0);
    finish_run();

    // watchdog on stage 2
    rdy = '{0, 0, 1000, 0};
    dn  = '{1, 2, 0, 1};
    launch(4'b1111, 1'b1);
    finish_run();
    repeat (3) @(negedge clk);
    chk("err_sticky", m_err, 1);
    rdy = '{0, 0, 0, 0};
    dn  = '{1, 2, 3, 1};
    launch(4'b1111, 1'b1);
    chk("err_clear", m_err, 0);
    finish_run();

    // reset during stage 1
    rdy = '{0, 100, 0, 0};
    dn  = '{1, 50, 1, 1};
    launch(4'b1111, 1'b0);
    w = 0;
    while (m_cur != 3'd1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("reach_s1", m_cur, 1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < NS; i++) hexp[i] = -1;
    reset = 1'b1;
    #1;
    chk("rst_start_now", m_start, 0);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    chk("mid_idle", m_idle, 1);
    chk("mid_start", m_start, 0);
    chk("mid_cur", m_cur, 0);
    for (int i = 0; i < NS; i++) check_cnt(i, 0);
    rdy = '{0, 0, 0, 0};
    dn  = '{1, 1, 1, 1};
    launch(4'b1111, 1'b0);
    finish_run();

    // empty mask
    launch(4'b0000, 1'b0);
    finish_run();

    // spurious done/ready on stage 3, mask changed after accept
    dn = '{6, 1, 1, 1};
    spur_on = 1'b1;
    launch(4'b1111, 1'b0);
    stage_en = 4'b0000;
    finish_run();
    spur_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
